spi_peripheral_rx: RTL and testbench
====================================

// Module: spi_peripheral_rx
// PURPOSE
//  SPI responder (mode 0: CPOL=0, CPHA=0, MSB first), the far end of our SPI controller.
//  Samples external SCLK/CS_n/MOSI through synchronisers in the clk_i domain and
//  deserialises MOSI into DATA_W-bit words. It also serialises a parallel TX word onto MISO.
//  Sits between the board SPI pins and the local word-level consumer/producer logic.
// PARAMETERS
//  DATA_W       8   bits per word (>=2)
//  SYNC_STAGES  2   synchroniser flops on sclk_i, cs_n_i, mosi_i (>=2)
//  CNT_W        10  width of completed-word counter
// PORTS
//  clk_i           in   1        system clock; must be >= 4x SCLK frequency
//  rst_ni          in   1        async reset, active low
//  sclk_i          in   1        SPI clock from controller (asynchronous)
//  cs_n_i          in   1        chip select, active low (asynchronous)
//  mosi_i          in   1        serial data from controller
//  miso_o          out  1        serial data to controller
//  miso_oe_o       out  1        MISO output enable (1 while selected)
//  tx_data_i       in   DATA_W   next word to transmit
//  tx_valid_i      in   1        tx_data_i holds a valid word
//  tx_ready_o      out  1        1-cycle pulse: tx_data_i consumed this cycle
//  rx_data_o       out  DATA_W   last received word
//  rx_valid_o      out  1        rx_data_o valid; held until rx_ack_i
//  rx_ack_i        in   1        consumer has taken rx_data_o
//  rx_overrun_o    out  1        sticky: word completed while rx_valid_o=1
//  tx_underrun_o   out  1        sticky: load point reached with tx_valid_i=0
//  frame_err_o     out  1        sticky: CS_n rose with partial word
//  word_count_o    out  CNT_W    completed words since reset/clear, wraps
//  clear_i         in   1        clears sticky flags and word_count_o
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; armed=0. CS sync flops reset to 1; other sync flops reset to 0.
//  Edges come from the last two synced samples. Edge-driven actions occur the cycle after detection.
//  Resulting latency is SYNC_STAGES+2 clk from the pin edge.
//  armed: set when synced CS_n=1. A frame may start only when armed=1.
//  After reset with CS held low, the block stays in IDLE until CS_n goes high, then low.
//  IDLE -> ACTIVE on CS_n fall (armed). Clear bit_cnt.
//   Load tx_shift <= tx_valid_i ? tx_data_i : 0. Pulse tx_ready_o if tx_valid_i.
//   Else set tx_underrun_o.
//  ACTIVE:
//   - SCLK rise: rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}; bit_cnt++.
//   - On the DATA_W-th rise: rx_data_o <= new word; set rx_valid_o; bit_cnt<=0;
//     word_count_o++ (wraps 2^CNT_W-1 -> 0).
//     If rx_valid_o already 1 and no rx_ack_i this cycle: set rx_overrun_o; data overwritten.
//   - SCLK fall, bit_cnt!=0: tx_shift <<= 1.
//   - SCLK fall, bit_cnt==0 after a completed word: reload tx_shift using the same rule as the frame start.
//     This gives back-to-back words within one CS.
//   - CS_n rise: -> IDLE. If bit_cnt!=0, set frame_err_o and discard the partial word.
//     Leave rx_data_o and word_count_o unchanged.
//  miso_o = tx_shift[DATA_W-1] in ACTIVE, 0 in IDLE. miso_oe_o = (state==ACTIVE).
//  rx_ack_i clears rx_valid_o. If ack and word completion fall in the same cycle:
//   rx_valid_o stays 1 and no overrun.
//  clear_i clears the sticky flags and word_count_o. A set event in the same cycle wins over clear_i.
//  Simultaneous SCLK edge and CS_n rise: CS_n rise wins; the edge is ignored.
//  Reset asserted mid-frame: immediate return to reset values; the partial word is lost.
// TESTING
//  1 CS low, tx 0x3C valid, MOSI 0xA5, 8 clks, CS high.
//    -> rx_data_o=0xA5, rx_valid_o=1, word_count_o=1.
//    -> controller samples MISO 0x3C; one tx_ready_o pulse.
//  2 One CS, MOSI 0x81,0x7E; TX 0x55,0xAA; ack after each word.
//    -> 2 rx_valid events with correct data; MISO 0x55 then 0xAA.
//    -> 2 tx_ready_o pulses; no flags set.
//  3 tx_valid_i=0 at frame start -> MISO 0x00, tx_underrun_o=1; clear_i -> 0.
//  4 Two words 0x11,0x22 with no ack -> rx_overrun_o=1, rx_data_o=0x22.
//    Ack + completion in same cycle -> no overrun.
//  5 CS high after 3 SCLK -> frame_err_o=1, rx_valid_o=0, word_count_o unchanged.
//    Next full frame 0xC3 received OK.
//  6 Reset mid-word with CS held low -> outputs 0, no frame until CS high->low.
//    Preload word_count_o=1023 via 1023 frames + 1 more -> wraps to 0.

Source files
------------

// File: rtl/spi_peripheral_rx.sv
// SPI mode-0 responder: synchronises SCLK/CS_n/MOSI into clk_i, deserialises MOSI into
// DATA_W-bit words and serialises parallel TX words onto MISO, MSB first.
module spi_peripheral_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ack_i,
    output logic              rx_overrun_o,
    output logic              tx_underrun_o,
    output logic              frame_err_o,
    output logic [CNT_W-1:0]  word_count_o,
    input  logic              clear_i
);

    localparam int BW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, fill;
    logic sclk_s, cs_s, mosi_s, filled;
    logic sclk_d, cs_d;
    logic sclk_rise_q, sclk_fall_q, cs_fall_q, cs_rise_q, mosi_q;
    logic armed, word_done;
    logic [BW-1:0] bit_cnt;
    logic [DATA_W-1:0] rx_shift, tx_shift, rx_next;
    logic start, stop, rise_act, fall_act, word_cmpl, load;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    // The CS chain resets to 1, so its output only reflects the pin once the chain has filled.
    assign filled = fill[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync   <= '0;
            cs_sync     <= '1;
            mosi_sync   <= '0;
            fill        <= '0;
            sclk_d      <= 1'b0;
            cs_d        <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            fill        <= {fill[SYNC_STAGES-2:0], 1'b1};
            sclk_d      <= sclk_s;
            cs_d        <= cs_s;
            sclk_rise_q <= sclk_s & ~sclk_d;
            sclk_fall_q <= ~sclk_s & sclk_d;
            cs_fall_q   <= cs_d & ~cs_s;
            cs_rise_q   <= ~cs_d & cs_s;
            mosi_q      <= mosi_s;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        stop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall_q && armed) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise_q) begin
                    state_d = IDLE;
                    stop    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A CS_n rise masks any SCLK edge detected in the same cycle.
    assign rise_act  = (state_q == ACTIVE) && !cs_rise_q && sclk_rise_q;
    assign fall_act  = (state_q == ACTIVE) && !cs_rise_q && sclk_fall_q;
    assign word_cmpl = rise_act && (bit_cnt == LAST_BIT);
    assign load      = start || (fall_act && (bit_cnt == '0) && word_done);
    assign rx_next   = {rx_shift[DATA_W-2:0], mosi_q};

    // Handshakes: tx_ready_o pulses for one cycle when tx_data_i is taken (only if tx_valid_i);
    // rx_valid_o holds until rx_ack_i, and an ack coinciding with a new word keeps it set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            armed         <= 1'b0;
            word_done     <= 1'b0;
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            tx_ready_o    <= 1'b0;
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            rx_overrun_o  <= 1'b0;
            tx_underrun_o <= 1'b0;
            frame_err_o   <= 1'b0;
            word_count_o  <= '0;
        end else begin
            tx_ready_o <= 1'b0;

            if (start)                armed <= 1'b0;
            else if (filled && cs_s)  armed <= 1'b1;

            if (start || stop) begin
                bit_cnt   <= '0;
                word_done <= 1'b0;
            end else if (rise_act) begin
                rx_shift <= rx_next;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt   <= '0;
                    word_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (load) begin
                word_done <= 1'b0;
            end

            if (load) begin
                tx_shift   <= tx_valid_i ? tx_data_i : '0;
                tx_ready_o <= tx_valid_i;
            end else if (fall_act && (bit_cnt != '0)) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            if (word_cmpl)     rx_data_o <= rx_next;

            if (word_cmpl)     rx_valid_o <= 1'b1;
            else if (rx_ack_i) rx_valid_o <= 1'b0;

            if (word_cmpl)     word_count_o <= word_count_o + 1'b1;
            else if (clear_i)  word_count_o <= '0;

            if (word_cmpl && rx_valid_o && !rx_ack_i) rx_overrun_o <= 1'b1;
            else if (clear_i)                         rx_overrun_o <= 1'b0;

            if (load && !tx_valid_i) tx_underrun_o <= 1'b1;
            else if (clear_i)        tx_underrun_o <= 1'b0;

            if (stop && (bit_cnt != '0)) frame_err_o <= 1'b1;
            else if (clear_i)            frame_err_o <= 1'b0;
        end
    end

    assign miso_o    = (state_q == ACTIVE) ? tx_shift[DATA_W-1] : 1'b0;
    assign miso_oe_o = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_peripheral_rx.sv
// Directed and randomized bench for spi_peripheral_rx acting as an SPI mode-0 controller,
// with a TX producer, an RX consumer and a word-level reference model.
module tb_spi_peripheral_rx;

    logic       clk, rst_n;
    logic       sclk_i, cs_n_i, mosi_i, miso_o, miso_oe_o;
    logic [7:0] tx_data_i, rx_data_o;
    logic       tx_valid_i, tx_ready_o, rx_valid_o, rx_ack_i;
    logic       rx_overrun_o, tx_underrun_o, frame_err_o, clear_i;
    logic [9:0] word_count_o;
    logic       ack_auto, ack_manual;

    int checks = 0;
    int failures = 0;

    logic [7:0] mosi_w[8];
    logic [7:0] miso_got[8];
    logic [7:0] tx_w[8];
    logic [7:0] rx_got[$];
    int         tx_n = 0;
    int         tx_pulses = 0;
    bit         auto_ack = 0;
    int         exp_count = 0;

    assign rx_ack_i = ack_auto | ack_manual;

    spi_peripheral_rx #(.DATA_W(8), .SYNC_STAGES(2), .CNT_W(10)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sclk_i(sclk_i), .cs_n_i(cs_n_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .miso_oe_o(miso_oe_o), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_ack_i(rx_ack_i), .rx_overrun_o(rx_overrun_o), .tx_underrun_o(tx_underrun_o),
        .frame_err_o(frame_err_o), .word_count_o(word_count_o), .clear_i(clear_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // TX producer: offers tx_w[0..tx_n-1] in order, advancing on every tx_ready_o pulse.
    initial begin
        tx_valid_i = 1'b0;
        tx_data_i  = 8'h00;
        forever begin
            tick();
            if (tx_ready_o) tx_pulses++;
            tx_valid_i = (tx_pulses < tx_n);
            tx_data_i  = (tx_pulses < tx_n) ? tx_w[tx_pulses] : 8'h00;
        end
    end

    // RX consumer: when auto_ack is on, records each word and acks it for one cycle.
    initial begin
        ack_auto = 1'b0;
        forever begin
            tick();
            if (ack_auto) ack_auto = 1'b0;
            else if (auto_ack && rx_valid_o) begin
                rx_got.push_back(rx_data_o);
                ack_auto = 1'b1;
            end
        end
    end

    task automatic set_tx(input int n);
        tx_pulses = 0;
        tx_n = n;
        repeat (2) tick();
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        tick();
    endtask

    task automatic pulse_ack();
        ack_manual = 1'b1;
        tick();
        ack_manual = 1'b0;
        tick();
    endtask

    // One CS frame of nbits bits from mosi_w; MISO sampled at each SCLK rise. The final SCLK
    // fall coincides with the CS_n rise, so no word is fetched past the end of the frame.
    task automatic run_frame(input int nbits, input int half, input bit ack_last);
        logic [7:0] w;
        cs_n_i = 1'b0;
        repeat (8) tick();
        for (int b = 0; b < nbits; b++) begin
            w = mosi_w[b / 8];
            mosi_i = w[7 - (b % 8)];
            repeat (half) tick();
            sclk_i = 1'b1;
            miso_got[b / 8][7 - (b % 8)] = miso_o;
            for (int j = 1; j <= half; j++) begin
                tick();
                if (ack_last && (b == nbits - 1)) begin
                    if (j == 3)      ack_manual = 1'b1;
                    else if (j == 4) ack_manual = 1'b0;
                end
            end
            sclk_i = 1'b0;
            if (b == nbits - 1) cs_n_i = 1'b1;
        end
        repeat (8) tick();
    endtask

    initial begin
        int nw, nt;
        rst_n = 1'b0; sclk_i = 1'b0; cs_n_i = 1'b1; mosi_i = 1'b0;
        clear_i = 1'b0; ack_manual = 1'b0;
        repeat (5) tick();
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_count", word_count_o, 0);
        check("rst_miso_oe", miso_oe_o, 0);
        check("rst_flags", {rx_overrun_o, tx_underrun_o, frame_err_o, tx_ready_o}, 0);
        rst_n = 1'b1;
        repeat (5) tick();

        // Single word, TX valid
        tx_w[0] = 8'h3C; set_tx(1);
        mosi_w[0] = 8'hA5;
        run_frame(8, 6, 0);
        exp_count = 1;
        check("t1_rx_data", rx_data_o, 8'hA5);
        check("t1_rx_valid", rx_valid_o, 1);
        check("t1_count", word_count_o, exp_count);
        check("t1_miso", miso_got[0], 8'h3C);
        check("t1_tx_pulses", tx_pulses, 1);
        check("t1_miso_oe_idle", miso_oe_o, 0);
        pulse_ack();
        check("t1_ack_clears", rx_valid_o, 0);

        // Two back-to-back words in one frame with acks
        tx_w[0] = 8'h55; tx_w[1] = 8'hAA; set_tx(2);
        mosi_w[0] = 8'h81; mosi_w[1] = 8'h7E;
        rx_got.delete(); auto_ack = 1;
        run_frame(16, 6, 0);
        exp_count += 2;
        check("t2_rx_events", rx_got.size(), 2);
        check("t2_rx0", rx_got[0], 8'h81);
        check("t2_rx1", rx_got[1], 8'h7E);
        check("t2_miso0", miso_got[0], 8'h55);
        check("t2_miso1", miso_got[1], 8'hAA);
        check("t2_tx_pulses", tx_pulses, 2);
        check("t2_flags", {rx_overrun_o, tx_underrun_o, frame_err_o}, 0);
        check("t2_count", word_count_o, exp_count);

        // TX underrun
        set_tx(0);
        mosi_w[0] = 8'h5A;
        run_frame(8, 6, 0);
        check("t3_miso_zero", miso_got[0], 8'h00);
        check("t3_underrun", tx_underrun_o, 1);
        pulse_clear();
        exp_count = 0;
        check("t3_clear_underrun", tx_underrun_o, 0);
        check("t3_clear_count", word_count_o, 0);

        // Overrun, then ack coinciding with completion
        auto_ack = 0;
        mosi_w[0] = 8'h11; mosi_w[1] = 8'h22;
        run_frame(16, 6, 0);
        check("t4_overrun", rx_overrun_o, 1);
        check("t4_rx_data", rx_data_o, 8'h22);
        check("t4_count", word_count_o, 2);
        pulse_clear();
        mosi_w[0] = 8'h33;
        run_frame(8, 6, 1);
        check("t4_same_cycle_no_overrun", rx_overrun_o, 0);
        check("t4_same_cycle_valid", rx_valid_o, 1);
        check("t4_same_cycle_data", rx_data_o, 8'h33);
        pulse_ack();
        pulse_clear();
        exp_count = 0;

        // Partial frame, then a good one
        mosi_w[0] = 8'hF0;
        run_frame(3, 6, 0);
        check("t5_frame_err", frame_err_o, 1);
        check("t5_rx_valid", rx_valid_o, 0);
        check("t5_count", word_count_o, exp_count);
        pulse_clear();
        mosi_w[0] = 8'hC3;
        run_frame(8, 6, 0);
        exp_count += 1;
        check("t5_rx_data", rx_data_o, 8'hC3);
        check("t5_rx_valid_ok", rx_valid_o, 1);
        check("t5_no_frame_err", frame_err_o, 0);
        check("t5_count_ok", word_count_o, exp_count);
        pulse_ack();

        // Randomized frames against the word-level model
        auto_ack = 1;
        for (int f = 0; f < 4; f++) begin
            nw = $urandom_range(1, 3);
            nt = $urandom_range(0, nw);
            for (int i = 0; i < nw; i++) begin
                mosi_w[i] = 8'($urandom);
                tx_w[i]   = 8'($urandom);
            end
            pulse_clear();
            exp_count = 0;
            rx_got.delete();
            set_tx(nt);
            run_frame(nw * 8, 6, 0);
            exp_count = (exp_count + nw) % 1024;
            check("rnd_rx_events", rx_got.size(), nw);
            for (int i = 0; i < nw; i++) begin
                check("rnd_rx_word", (i < rx_got.size()) ? rx_got[i] : 8'hxx, mosi_w[i]);
                check("rnd_miso_word", miso_got[i], (i < nt) ? tx_w[i] : 8'h00);
            end
            check("rnd_tx_pulses", tx_pulses, nt);
            check("rnd_underrun", tx_underrun_o, (nt < nw) ? 1 : 0);
            check("rnd_overrun", rx_overrun_o, 0);
            check("rnd_count", word_count_o, exp_count);
        end

        // Reset mid-word with CS held low
        auto_ack = 0;
        cs_n_i = 1'b0;
        repeat (8) tick();
        repeat (3) begin
            mosi_i = 1'b1; repeat (4) tick();
            sclk_i = 1'b1; repeat (4) tick();
            sclk_i = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) tick();
        check("t6_rst_count", word_count_o, 0);
        check("t6_rst_miso_oe", miso_oe_o, 0);
        check("t6_rst_flags", {rx_valid_o, rx_overrun_o, tx_underrun_o, frame_err_o}, 0);
        rst_n = 1'b1;
        repeat (10) tick();
        check("t6_idle_after_rst", miso_oe_o, 0);
        repeat (8) begin
            mosi_i = 1'b1; repeat (4) tick();
            sclk_i = 1'b1; repeat (4) tick();
            sclk_i = 1'b0;
        end
        repeat (6) tick();
        check("t6_no_frame_count", word_count_o, 0);
        check("t6_no_frame_valid", rx_valid_o, 0);
        cs_n_i = 1'b1;
        repeat (8) tick();

        // Counter wrap
        auto_ack = 1;
        set_tx(0);
        exp_count = 0;
        for (int f = 0; f < 1023; f++) begin
            mosi_w[0] = 8'(f);
            run_frame(8, 2, 0);
            exp_count = (exp_count + 1) % 1024;
        end
        check("t6_count_1023", word_count_o, exp_count);
        rx_got.delete();
        mosi_w[0] = 8'hE7;
        run_frame(8, 2, 0);
        exp_count = (exp_count + 1) % 1024;
        check("t6_count_wrap", word_count_o, exp_count);
        check("t6_last_word", (rx_got.size() > 0) ? rx_got[0] : 8'hxx, 8'hE7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
